// File: rtl/mem_dump_reader.sv
// mem_dump_reader: reads a block of 16-bit data-memory words and streams them to the UART, high byte first.
// Define MEM_DUMP_CHECKSUM_EN to append an XOR checksum byte after the last word.
module mem_dump_reader #(
  parameter int AB = 11,
  parameter int DB = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [AB-1:0] Base_Addr,
  input  logic [AB:0]   Num_Words,
  output logic          RdRam,
  output logic          WrRam,
  output logic [AB-1:0] Addr,
  input  logic [DB-1:0] Mem_Data,
  output logic [7:0]    tx_data,
  output logic          tx_start,
  input  logic          tx_done,
  output logic          busy,
  output logic          done
);
`ifdef MEM_DUMP_CHECKSUM_EN
  typedef enum logic [3:0] {IDLE, RD, CAP, TX_HI, WAIT_HI, TX_LO, WAIT_LO, NEXT, CHK, WAIT_CHK, FIN} state_t;
  localparam state_t LAST = CHK;
`else
  typedef enum logic [3:0] {IDLE, RD, CAP, TX_HI, WAIT_HI, TX_LO, WAIT_LO, NEXT, FIN} state_t;
  localparam state_t LAST = FIN;
`endif
  localparam logic [AB:0] ONE = 1;
  state_t        r_state, w_next;
  logic [AB-1:0] r_addr;
  logic [AB:0]   r_cnt;
  logic [7:0]    r_lo;
  logic [7:0]    r_tx_data;
`ifdef MEM_DUMP_CHECKSUM_EN
  logic [7:0]    r_chk;
`endif
  always_ff @(posedge clk or posedge reset)
    if (reset) r_state <= IDLE;
    else r_state <= w_next;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:     if (start) w_next = (Num_Words == '0) ? FIN : RD;
      RD:       w_next = CAP;
      CAP:      w_next = TX_HI;
      TX_HI:    w_next = WAIT_HI;
      WAIT_HI:  if (tx_done) w_next = TX_LO;
      TX_LO:    w_next = WAIT_LO;
      WAIT_LO:  if (tx_done) w_next = NEXT;
      NEXT:     w_next = (r_cnt != ONE) ? RD : LAST;
`ifdef MEM_DUMP_CHECKSUM_EN
      CHK:      w_next = WAIT_CHK;
      WAIT_CHK: if (tx_done) w_next = FIN;
`endif
      default:  w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_addr    <= '0;
      r_cnt     <= '0;
      r_lo      <= '0;
      r_tx_data <= '0;
`ifdef MEM_DUMP_CHECKSUM_EN
      r_chk     <= '0;
`endif
    end else begin
      if (r_state == IDLE && start) begin
        r_addr <= Base_Addr;
        r_cnt  <= Num_Words;
`ifdef MEM_DUMP_CHECKSUM_EN
        r_chk  <= '0;
`endif
      end
      // Memory drove Out_Data on the falling edge inside RD, so it is stable here.
      if (r_state == CAP) begin
        r_lo      <= Mem_Data[7:0];
        r_tx_data <= Mem_Data[15:8];
      end
      if (r_state == WAIT_HI && tx_done) r_tx_data <= r_lo;
`ifdef MEM_DUMP_CHECKSUM_EN
      if (r_state == TX_HI || r_state == TX_LO) r_chk <= r_chk ^ r_tx_data;
`endif
      if (r_state == NEXT) begin
        r_cnt  <= r_cnt - ONE;
        r_addr <= r_addr + AB'(1);
`ifdef MEM_DUMP_CHECKSUM_EN
        r_tx_data <= r_chk;
`endif
      end
    end
  assign RdRam    = (r_state == RD);
  assign WrRam    = 1'b0;
  assign Addr     = r_addr;
  assign tx_data  = r_tx_data;
`ifdef MEM_DUMP_CHECKSUM_EN
  assign tx_start = (r_state == TX_HI) || (r_state == TX_LO) || (r_state == CHK);
`else
  assign tx_start = (r_state == TX_HI) || (r_state == TX_LO);
`endif
  assign busy     = (r_state != IDLE);
  assign done     = (r_state == FIN);
endmodule
